serv_dbus_ram: RTL and testbench

Wishbone data-bus responder that terminates the SERV core's data-memory port. It accepts the word address, write data, byte selects and write enable driven by the core's memory interface. It performs byte-lane-masked writes or full-word reads on an internal RAM and returns data with a single-cycle acknowledge after a programmable number of wait states. It sits between the core's dbus and on-chip data RAM, and doubles as a latency-injecting bus model for verification.

---
 rtl/serv_dbus_ram.sv | 140 ++++++++++++++
 tb/tb_serv_dbus_ram.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serv_dbus_ram.sv
// Wishbone data-bus RAM responder for the SERV dbus: byte-masked writes, full-word
// reads, one-cycle ack after a fixed number of wait states.
module serv_dbus_ram #(
  parameter int    DEPTH       = 256,
  parameter int    WAIT_STATES = 0,
  parameter string MEMFILE     = ""
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack
);

  localparam int         AW = $clog2(DEPTH);
  localparam int         IW = (AW > 2) ? AW - 2 : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("serv_dbus_ram: DEPTH must be a power of two and at least 4");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("serv_dbus_ram: WAIT_STATES must be within 0..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept, complete;

  logic [IW-1:0] in_idx;
  logic [IW-1:0] idx_q;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [31:0]   dat_q;

  logic [IW-1:0] acc_idx;
  logic          acc_we;
  logic [3:0]    acc_sel;
  logic [31:0]   acc_dat;

  logic [31:0]   mem [2**IW];
  logic [31:0]   rdt_q;

  // Offset bits and bits above the RAM size are ignored, so addresses alias.
  logic unused_adr;
  assign unused_adr = ^i_wb_adr;

  if (AW > 2) begin : g_idx
    assign in_idx = i_wb_adr[AW-1:2];
  end else begin : g_idx_single
    assign in_idx = '0;
  end

  assign o_wb_ack = (state_q == ACK);
  assign o_wb_rdt = rdt_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_wb_cyc && !o_wb_ack) begin
          accept = 1'b1;
          cnt_d  = WS;
          if (WS == 4'd0) begin
            state_d  = ACK;
            complete = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = ACK;
          complete = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access completes on the accepting edge, before the latch holds it.
  always_comb begin
    if (state_q == IDLE) begin
      acc_idx = in_idx;
      acc_we  = i_wb_we;
      acc_sel = i_wb_sel;
      acc_dat = i_wb_dat;
    end else begin
      acc_idx = idx_q;
      acc_we  = we_q;
      acc_sel = sel_q;
      acc_dat = dat_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (complete && !acc_we) rdt_q <= mem[acc_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      idx_q <= in_idx;
      we_q  <= i_wb_we;
      sel_q <= i_wb_sel;
      dat_q <= i_wb_dat;
    end
  end

  // NOTE: RAM and request latches carry no reset; contents must survive a reset pulse.
  always_ff @(posedge i_clk) begin
    if (complete && acc_we && i_rst_n) begin
      for (int n = 0; n < 4; n++) begin
        if (acc_sel[n]) mem[acc_idx][8*n +: 8] <= acc_dat[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_serv_dbus_ram.sv
// Bench for serv_dbus_ram: one instance with no wait states, one with three, checked
// against a byte-addressed reference memory.
module tb_serv_dbus_ram;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0][31:0] adr, dat, rdt;
  logic [1:0][3:0]  sel;
  logic [1:0]       we, cyc, ack;

  always #5 clk = ~clk;

  serv_dbus_ram #(.DEPTH(256), .WAIT_STATES(0), .MEMFILE("")) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr[0]), .i_wb_dat(dat[0]),
    .i_wb_sel(sel[0]), .i_wb_we(we[0]), .i_wb_cyc(cyc[0]),
    .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0])
  );

  serv_dbus_ram #(.DEPTH(256), .WAIT_STATES(3), .MEMFILE("")) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr[1]), .i_wb_dat(dat[1]),
    .i_wb_sel(sel[1]), .i_wb_we(we[1]), .i_wb_cyc(cyc[1]),
    .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1])
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  mm [2][256];
  logic [31:0] last_rdt [2];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int base_of(input logic [31:0] a);
    return int'(a % 32'd256) & ~3;
  endfunction

  function automatic logic [31:0] mword(input int d, input logic [31:0] a);
    int b = base_of(a);
    return {mm[d][b+3], mm[d][b+2], mm[d][b+1], mm[d][b]};
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] s);
    int b = base_of(a);
    for (int n = 0; n < 4; n++) if (s[n]) mm[d][b+n] = wd[8*n +: 8];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete bus transaction; 'early' drops cyc right after acceptance.
  task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input bit early, input string tag);
    int lat;
    @(negedge clk);
    adr[d] = a; dat[d] = wd; sel[d] = s; we[d] = w; cyc[d] = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (early) cyc[d] = 1'b0;
      if (ack[d]) begin
        lat = k;
        break;
      end
      @(posedge clk);
    end
    check({tag, "/latency"}, 32'(lat), 32'(ws_of(d)));
    if (lat >= 0) begin
      if (w) begin
        model_write(d, a, wd, s);
        check({tag, "/rdt_hold"}, rdt[d], last_rdt[d]);
      end else begin
        last_rdt[d] = mword(d, a);
        check({tag, "/rdata"}, rdt[d], last_rdt[d]);
      end
    end
    @(negedge clk);
    cyc[d] = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "/ack_one_cycle"}, {31'b0, ack[d]}, 32'h0);
  endtask

  initial begin
    int first, second;
    rst_n = 1'b0;
    adr = '0; dat = '0; sel = '0; we = '0; cyc = '0;
    last_rdt[0] = 32'h0;
    last_rdt[1] = 32'h0;

    // Reset, then idle with cyc low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("reset_idle/ack", {31'b0, ack[d]}, 32'h0);
        check("reset_idle/rdt", rdt[d], 32'h0);
      end
    end

    // Fill both RAMs so every model byte is defined.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++)
        access(d, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, "fill");

    // Full-word write and read, no wait states.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "ws0_write");
    access(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, "ws0_read");
    check("ws0_read/const", rdt[0], 32'hDEADBEEF);

    // Byte-lane masking and empty select.
    access(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, "mask_preload");
    access(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, "mask_write");
    access(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, "mask_read");
    check("mask_read/const", rdt[0], 32'h11BB33DD);
    access(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0, "sel0_write");
    access(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, "sel0_read");
    check("sel0_read/const", rdt[0], 32'h11BB33DD);

    // Three wait states with cyc held across two back-to-back reads.
    @(negedge clk);
    adr[1] = 32'h20; we[1] = 1'b0; sel[1] = 4'hF; cyc[1] = 1'b1;
    @(posedge clk);
    first = -1;
    second = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (ack[1]) begin
        if (first < 0) first = k;
        else begin
          second = k;
          break;
        end
      end
      @(posedge clk);
    end
    check("spacing/first_ack", 32'(first), 32'd3);
    check("spacing/second_ack", 32'(second), 32'd8);
    last_rdt[1] = mword(1, 32'h20);
    check("spacing/rdata", rdt[1], last_rdt[1]);
    @(negedge clk);
    cyc[1] = 1'b0;
    @(posedge clk);
    #1;
    check("spacing/ack_one_cycle", {31'b0, ack[1]}, 32'h0);

    // A request survives cyc dropping during the wait states.
    access(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 1'b1, "drop_cyc_write");
    access(1, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, "drop_cyc_read");
    check("drop_cyc_read/const", rdt[1], 32'hCAFEF00D);

    // Randomized mix on both instances, including aliased addresses.
    for (int i = 0; i < 60; i++)
      access(i % 2, 1'($urandom_range(0, 1)), $urandom, $urandom,
             4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), "random");

    // Aliasing modulo DEPTH.
    access(1, 1'b1, 32'h104, 32'h12345678, 4'hF, 1'b0, "alias_write");
    access(1, 1'b0, 32'h004, 32'h0, 4'hF, 1'b0, "alias_read");
    check("alias_read/const", rdt[1], 32'h12345678);

    // Reset pulse while a write is waiting: no ack, RAM untouched.
    @(negedge clk);
    adr[1] = 32'h004; dat[1] = 32'h0; sel[1] = 4'hF; we[1] = 1'b1; cyc[1] = 1'b1;
    @(posedge clk);
    #1;
    check("abort/ack_before_reset", {31'b0, ack[1]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    cyc[1] = 1'b0;
    #1;
    check("abort/ack_in_reset", {31'b0, ack[1]}, 32'h0);
    check("abort/rdt_in_reset", rdt[1], 32'h0);
    #2;
    rst_n = 1'b1;
    last_rdt[0] = 32'h0;
    last_rdt[1] = 32'h0;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("abort/no_ack", {31'b0, ack[1]}, 32'h0);
    end
    access(1, 1'b0, 32'h004, 32'h0, 4'hF, 1'b0, "abort_read");
    check("abort_read/const", rdt[1], 32'h12345678);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
